// File: rtl/dp_seq_pkg.sv
// dp_seq_pkg: shared types and constants for the dp_sequencer slice.
//   dp_seq_state_t : sequencer states (IDLE, CLEAR, SETTLE, MEASURE)
//   ADC_W / DB_W   : ADC sample width and DataPath dB result width
//   WDOG_MULT      : watchdog limit in units of ADC sample periods
package dp_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_SETTLE,
    ST_MEASURE
  } dp_seq_state_t;

  localparam int ADC_W     = 12;
  localparam int DB_W      = 16;
  localparam int WDOG_MULT = 4;

endpackage

// File: rtl/dp_sequencer_conv_strobe_gen.sv
// conv_strobe_gen: ADC convert strobe divider.
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : count enable; counter is held at 0 while low
//   restart    : synchronous clear of counter and strobe
//   conv       : registered one-cycle strobe, high while the count is CLK_DIV-1
// CLK_DIV must be >= 2.
module conv_strobe_gen #(
  parameter int CLK_DIV = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic restart,
  output logic conv
);

  localparam int CNT_W = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;

  // NOTE: combinational blocks assign every output unconditionally first so
  // no path can leave a value held, which would infer a latch.
  always_comb begin
    cnt_nxt = cnt + CNT_W'(1);
    if (cnt == LAST) cnt_nxt = '0;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      conv <= 1'b0;
    end else if (restart || !en) begin
      cnt  <= '0;
      conv <= 1'b0;
    end else begin
      cnt  <= cnt_nxt;
      // Strobe is registered from the next count, so it is high exactly
      // while cnt == CLK_DIV-1.
      conv <= (cnt_nxt == LAST);
    end
  end

endmodule

// File: rtl/dp_sequencer.sv
// dp_sequencer: sequences the receiver DataPath for one measurement run.
// Clears the datapath, gates ADC samples into it, discards dB results while
// the filters settle, and reports the peak dB value of each fixed window.
//   clk, rst_n           : clock, asynchronous active-low reset
//   start_i / stop_i     : run request (IDLE only) / abort (wins over start)
//   continuous_i         : sampled at window end, 1 keeps measuring
//   adc_conv_o           : ADC convert strobe, one cycle every CLK_DIV cycles
//   adc_sample_i/_valid_i: ADC sample and qualifier
//   dp_clear_o, dp_en_o  : DataPath reset and enable
//   dp_sample_o/_valid_o : registered sample and qualifier to DataPath
//   dp_db_i/_valid_i     : unsigned dB result from DataPath
//   peak_db_o/_valid_o   : peak of last completed window, update pulse
//   busy_o               : state != IDLE
//   fault_o              : sticky watchdog timeout (macro DP_SEQ_TIMEOUT_EN),
//                          tied to 0 when the macro is undefined
// CLEAR_CYCLES, SETTLE_RESULTS and WINDOW_LEN must be >= 1, CLK_DIV >= 2.
module dp_sequencer
  import dp_seq_pkg::*;
#(
  parameter int CLK_DIV        = 10,
  parameter int CLEAR_CYCLES   = 4,
  parameter int SETTLE_RESULTS = 1000,
  parameter int WINDOW_LEN     = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             stop_i,
  input  logic             continuous_i,
  output logic             adc_conv_o,
  input  logic [ADC_W-1:0] adc_sample_i,
  input  logic             adc_sample_valid_i,
  output logic             dp_clear_o,
  output logic             dp_en_o,
  output logic [ADC_W-1:0] dp_sample_o,
  output logic             dp_sample_valid_o,
  input  logic [DB_W-1:0]  dp_db_i,
  input  logic             dp_db_valid_i,
  output logic [DB_W-1:0]  peak_db_o,
  output logic             peak_valid_o,
  output logic             busy_o,
  output logic             fault_o
);

  localparam int CLR_W = $clog2(CLEAR_CYCLES + 1);
  localparam int SET_W = $clog2(SETTLE_RESULTS + 1);
  localparam int WIN_W = $clog2(WINDOW_LEN + 1);

  dp_seq_state_t    state;
  logic [CLR_W-1:0] clr_cnt;
  logic [SET_W-1:0] res_cnt;
  logic [WIN_W-1:0] win_cnt;
  logic [DB_W-1:0]  run_max;

  logic            in_run;
  logic            res_ok;
  logic            settle_done;
  logic            win_done;
  logic [DB_W-1:0] cand;
  logic            wdog_trip;
  logic            halt;

  always_comb begin
    in_run      = (state == ST_SETTLE) || (state == ST_MEASURE);
    res_ok      = dp_db_valid_i && in_run;
    settle_done = res_ok && (state == ST_SETTLE) &&
                  (res_cnt == SET_W'(SETTLE_RESULTS - 1));
    win_done    = res_ok && (state == ST_MEASURE) &&
                  (win_cnt == WIN_W'(WINDOW_LEN - 1));
    // First result of a window replaces whatever run_max held.
    cand        = run_max;
    if ((win_cnt == '0) || (dp_db_i > run_max)) cand = dp_db_i;
    // Every reason to leave SETTLE/MEASURE next cycle; also restarts the divider.
    halt        = stop_i || wdog_trip || (win_done && !continuous_i);
  end

`ifdef DP_SEQ_TIMEOUT_EN
  localparam int WD_LIMIT = WDOG_MULT * CLK_DIV;
  localparam int WD_W     = $clog2(WD_LIMIT + 1);

  logic [WD_W-1:0] wd_cnt;
  logic            fault_q;

  // wd_cnt holds the number of result-free cycles already seen; the trip
  // fires on the WD_LIMIT-th such cycle.
  assign wdog_trip = in_run && !dp_db_valid_i && (wd_cnt == WD_W'(WD_LIMIT - 1));
  assign fault_o   = fault_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt  <= '0;
      fault_q <= 1'b0;
    end else begin
      if ((state == ST_IDLE) && start_i && !stop_i) fault_q <= 1'b0;
      else if (wdog_trip)                          fault_q <= 1'b1;

      if (!in_run || dp_db_valid_i || halt) wd_cnt <= '0;
      else                                  wd_cnt <= wd_cnt + WD_W'(1);
    end
  end
`else
  assign wdog_trip = 1'b0;
  assign fault_o   = 1'b0;
`endif

  conv_strobe_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_conv (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (dp_en_o),
    .restart (halt),
    .conv    (adc_conv_o)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      clr_cnt      <= '0;
      res_cnt      <= '0;
      win_cnt      <= '0;
      run_max      <= '0;
      peak_db_o    <= '0;
      peak_valid_o <= 1'b0;
      dp_clear_o   <= 1'b0;
      dp_en_o      <= 1'b0;
      busy_o       <= 1'b0;
    end else begin
      peak_valid_o <= 1'b0;
      if (halt) begin
        state      <= ST_IDLE;
        clr_cnt    <= '0;
        res_cnt    <= '0;
        win_cnt    <= '0;
        run_max    <= '0;
        dp_clear_o <= 1'b0;
        dp_en_o    <= 1'b0;
        busy_o     <= 1'b0;
        // Non-continuous window end still reports; an abort never does.
        if (win_done && !stop_i) begin
          peak_db_o    <= cand;
          peak_valid_o <= 1'b1;
        end
      end else begin
        unique case (state)
          ST_IDLE: begin
            if (start_i) begin
              state      <= ST_CLEAR;
              clr_cnt    <= '0;
              dp_clear_o <= 1'b1;
              busy_o     <= 1'b1;
            end
          end
          ST_CLEAR: begin
            if (clr_cnt == CLR_W'(CLEAR_CYCLES - 1)) begin
              state      <= ST_SETTLE;
              dp_clear_o <= 1'b0;
              dp_en_o    <= 1'b1;
            end else begin
              clr_cnt <= clr_cnt + CLR_W'(1);
            end
          end
          ST_SETTLE: begin
            if (settle_done) begin
              res_cnt <= '0;
              state   <= ST_MEASURE;
            end else if (res_ok) begin
              res_cnt <= res_cnt + SET_W'(1);
            end
          end
          ST_MEASURE: begin
            if (res_ok) begin
              run_max <= cand;
              if (win_done) begin
                peak_db_o    <= cand;
                peak_valid_o <= 1'b1;
                win_cnt      <= '0;
              end else begin
                win_cnt <= win_cnt + WIN_W'(1);
              end
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  // Sample path: data holds while disabled, qualifier is forced low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dp_sample_o       <= '0;
      dp_sample_valid_o <= 1'b0;
    end else if (dp_en_o) begin
      dp_sample_o       <= adc_sample_i;
      dp_sample_valid_o <= adc_sample_valid_i;
    end else begin
      dp_sample_valid_o <= 1'b0;
    end
  end

endmodule
